// File: rtl/sd_pkg.sv
// Shared definitions for the second-order sigma-delta bitstream source.
// Holds the bitstream symbol encodings, the default rate/width constants
// (also used by the Mul_CIC loopback bench) and the saturating-add helper.
package sd_pkg;

    localparam int SD_DIN_W    = 16;
    localparam int SD_ACC_W    = 24;
    localparam int SD_CLK_DIV  = 98;
    localparam int SD_OSR      = 128;

    localparam logic signed [1:0] SD_BIT_POS = 2'sb01;
    localparam logic signed [1:0] SD_BIT_NEG = 2'sb11;

    // Three-term add clamped to an acc_w-bit signed range. Operands are
    // acc_w-bit values sign-extended to 64 bits, so the 64-bit sum is
    // exact (same value an acc_w+2 bit adder produces) and never wraps.
    function automatic logic signed [63:0] sd_sat_add(
        input logic signed [63:0] a,
        input logic signed [63:0] b,
        input logic signed [63:0] c,
        input int                 acc_w
    );
        logic signed [63:0] sum_v;
        logic signed [63:0] hi_v;
        logic signed [63:0] lo_v;
        sum_v = a + b + c;
        hi_v  = (64'sd1 <<< (acc_w - 1)) - 64'sd1;
        lo_v  = -(64'sd1 <<< (acc_w - 1));
        if (sum_v > hi_v) begin
            return hi_v;
        end else if (sum_v < lo_v) begin
            return lo_v;
        end else begin
            return sum_v;
        end
    endfunction

endpackage

// File: rtl/sd_mod2_bitgen_if.sv
// PCM sample handshake between a sample source and the sigma-delta modulator.
//   din       : signed PCM sample (source -> modulator)
//   din_valid : din is valid      (source -> modulator)
//   din_ready : holding register empty (modulator -> source)
// master = sample source, slave = modulator.
interface sd_mod2_bitgen_if
    import sd_pkg::*;
#(
    parameter int DIN_W = SD_DIN_W
);
    logic signed [DIN_W-1:0] din;
    logic                    din_valid;
    logic                    din_ready;

    modport master (output din, output din_valid, input din_ready);
    modport slave  (input din, input din_valid, output din_ready);

endinterface

// File: rtl/sd_tick_gen.sv
// Bit-rate divider and oversampling counter for the sigma-delta modulator.
//   clk, rst   : clock, synchronous active-high reset
//   enable     : freezes both counters when low
//   tick       : high during the cycle whose rising edge emits a new bit
//   load_tick  : tick that also closes an OSR period (PCM load point)
// The first tick edge is the CLK_DIV-th enabled edge after reset release.
module sd_tick_gen #(
    parameter int CLK_DIV = 98,
    parameter int OSR     = 128
) (
    input  logic clk,
    input  logic rst,
    input  logic enable,
    output logic tick,
    output logic load_tick
);

    localparam int DIV_W = $clog2(CLK_DIV);
    localparam int OSR_W = (OSR > 1) ? $clog2(OSR) : 1;

    logic [DIV_W-1:0] div_cnt_r;
    logic [OSR_W-1:0] osr_cnt_r;
    logic             tick_s;
    logic             load_tick_s;

    // Decode the terminal counts; disabled cycles never tick.
    always_comb begin
        tick_s      = 1'b0;
        load_tick_s = 1'b0;
        if (enable && (div_cnt_r == DIV_W'(CLK_DIV - 1))) begin
            tick_s = 1'b1;
            if (osr_cnt_r == OSR_W'(OSR - 1)) begin
                load_tick_s = 1'b1;
            end else begin
                load_tick_s = 1'b0;
            end
        end else begin
            tick_s      = 1'b0;
            load_tick_s = 1'b0;
        end
    end

    // Divider and OSR counters; both hold their phase while disabled.
    always_ff @(posedge clk) begin
        if (rst) begin
            div_cnt_r <= '0;
            osr_cnt_r <= '0;
        end else if (enable) begin
            if (tick_s) begin
                div_cnt_r <= '0;
                if (load_tick_s) begin
                    osr_cnt_r <= '0;
                end else begin
                    osr_cnt_r <= osr_cnt_r + OSR_W'(1);
                end
            end else begin
                div_cnt_r <= div_cnt_r + DIV_W'(1);
            end
        end
    end

    assign tick      = tick_s;
    assign load_tick = load_tick_s;

endmodule

// File: rtl/sd_mod2_bitgen.sv
// Second-order digital sigma-delta modulator: PCM in, 2-bit signed +/-1
// bitstream out, one bit every CLK_DIV clocks, one PCM word per OSR bits.
//   clk, rst   : clock, synchronous active-high reset
//   enable     : 0 freezes counters, integrators and outputs
//   pcm        : slave side of the din/din_valid/din_ready handshake
//   bit_out    : 2'b01 = +1, 2'b11 = -1 (2'b00 only after reset)
//   bit_valid  : one-cycle strobe per new bit_out
//   underrun   : sticky; a PCM load was due with the holding register empty
module sd_mod2_bitgen
    import sd_pkg::*;
#(
    parameter int DIN_W   = SD_DIN_W,
    parameter int ACC_W   = SD_ACC_W,
    parameter int CLK_DIV = SD_CLK_DIV,
    parameter int OSR     = SD_OSR
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 enable,
    sd_mod2_bitgen_if.slave      pcm,
    output logic [1:0]           bit_out,
    output logic                 bit_valid,
    output logic                 underrun
);

    // Feedback magnitude: full scale of the PCM word at integrator width.
    localparam logic signed [ACC_W-1:0] FS_A = ACC_W'(64'sd1 <<< (DIN_W - 1));

    logic signed [ACC_W-1:0] i1_r;
    logic signed [ACC_W-1:0] i2_r;
    logic signed [DIN_W-1:0] x_cur_r;
    logic signed [DIN_W-1:0] hold_r;
    logic                    hold_full_r;
    logic [1:0]              bit_out_r;
    logic                    bit_valid_r;
    logic                    underrun_r;

    logic                    tick_s;
    logic                    load_tick_s;
    logic                    y_pos_s;
    logic                    accept_s;
    logic signed [ACC_W-1:0] fb_s;
    logic signed [ACC_W-1:0] i1_nxt_s;
    logic signed [ACC_W-1:0] i2_nxt_s;

    sd_tick_gen #(
        .CLK_DIV (CLK_DIV),
        .OSR     (OSR)
    ) u_tick_gen (
        .clk       (clk),
        .rst       (rst),
        .enable    (enable),
        .tick      (tick_s),
        .load_tick (load_tick_s)
    );

    // Quantiser decision, feedback and next integrator values. Both
    // integrators use the pre-update i1/x_cur, so on a load tick the
    // old sample is still the one being integrated.
    always_comb begin
        y_pos_s  = ~i2_r[ACC_W-1];
        if (y_pos_s) begin
            fb_s = FS_A;
        end else begin
            fb_s = -FS_A;
        end
        i1_nxt_s = ACC_W'(sd_sat_add(64'(i1_r), 64'(x_cur_r), -64'(fb_s), ACC_W));
        i2_nxt_s = ACC_W'(sd_sat_add(64'(i2_r), 64'(i1_r), -64'(fb_s), ACC_W));
        accept_s = pcm.din_valid & ~hold_full_r;
    end

    // Modulator state and bitstream outputs, updated only on ticks.
    always_ff @(posedge clk) begin
        if (rst) begin
            i1_r        <= '0;
            i2_r        <= '0;
            x_cur_r     <= '0;
            bit_out_r   <= 2'b00;
            bit_valid_r <= 1'b0;
            underrun_r  <= 1'b0;
        end else if (enable) begin
            bit_valid_r <= tick_s;
            if (tick_s) begin
                bit_out_r <= y_pos_s ? SD_BIT_POS : SD_BIT_NEG;
                i1_r      <= i1_nxt_s;
                i2_r      <= i2_nxt_s;
            end
            if (load_tick_s) begin
                if (hold_full_r) begin
                    x_cur_r <= hold_r;
                end else begin
                    underrun_r <= 1'b1;
                end
            end
        end else begin
            bit_valid_r <= 1'b0;
        end
    end

    // Holding register. A load tick empties it; the handshake stays
    // live with enable low so din_ready always means "will accept".
    // Accept and load are exclusive: accept needs an empty register.
    always_ff @(posedge clk) begin
        if (rst) begin
            hold_r      <= '0;
            hold_full_r <= 1'b0;
        end else if (load_tick_s && hold_full_r) begin
            hold_full_r <= 1'b0;
        end else if (accept_s) begin
            hold_r      <= pcm.din;
            hold_full_r <= 1'b1;
        end
    end

    assign pcm.din_ready = ~hold_full_r;
    assign bit_out       = bit_out_r;
    assign bit_valid     = bit_valid_r;
    assign underrun      = underrun_r;

endmodule

// File: doc/sd_mod2_bitgen.md
Name: sd_mod2_bitgen

Overview:
- Second-order digital sigma-delta modulator. Converts PCM samples into a 2-bit signed ±1 bitstream.
- This is the bitstream source that feeds Mul_CIC's Xin, both on-chip and in loopback benches. It replaces the file-driven stimulus.
- Default rate: 50 MHz clk divided by 98, about 510 kHz bit rate. PCM is consumed once per OSR bits through a valid/ready handshake.

Parameters:
- DIN_W, 16: PCM input width, signed two's complement. Full scale FS = 2^(DIN_W-1).
- ACC_W, 24: integrator width, signed. Must be at least DIN_W+4.
- CLK_DIV, 98: clk cycles per output bit. Must be at least 2.
- OSR, 128: output bits per PCM sample. Matches the CIC decimation factor.

Ports:
- clk  in  1  system clock (50 MHz).
- rst  in  1  synchronous, active-high reset.
- enable  in  1  when 0, freezes all counters, integrators and outputs; bit_valid is forced to 0.
- din  in  DIN_W  signed PCM sample.
- din_valid  in  1  din is valid.
- din_ready  out  1  holding register is empty.
- bit_out  out  2  signed bitstream: 2'b01 = +1, 2'b11 = -1.
- bit_valid  out  1  one-cycle strobe per new bit_out value.
- underrun  out  1  sticky flag: a PCM load was due while the holding register was empty.

Behaviour:
- Reset values: bit_out=2'b00, bit_valid=0, underrun=0, din_ready=1. Integrators i1=i2=0, x_cur=0, div_cnt=0, osr_cnt=0, hold_full=0.
- Tick generation:
  - With enable=1, div_cnt counts 0..CLK_DIV-1.
  - tick is asserted when div_cnt==CLK_DIV-1; div_cnt then wraps to 0.
  - The first tick falls on the CLK_DIV-th enabled edge after reset release.
- Decision: y=+1 when i2>=0 (signed), else y=-1. fb = y ? +FS : -FS. y is combinational from the current i2.
- On each tick edge:
  - bit_out <= y encoding; bit_valid <= 1. On every other edge bit_valid <= 0.
  - i1 <= sat(i1 + x_cur - fb).
  - i2 <= sat(i2 + i1_old - fb), where i1_old is i1 before this update.
  - sat() clamps to [-2^(ACC_W-1), 2^(ACC_W-1)-1]. No wrap-around is permitted.
  - Sums are computed at ACC_W+2 bits before clamping.
- Handshake:
  - din_ready = !hold_full.
  - Transfer occurs on an edge where din_valid && din_ready: hold <= din, hold_full <= 1.
  - din must remain stable while din_valid=1 && din_ready=0.
- PCM load:
  - Each tick increments osr_cnt, wrapping at OSR-1.
  - On a tick with osr_cnt==OSR-1 (load tick):
    - If hold_full: x_cur <= hold and hold_full <= 0. din_ready rises the next cycle; there is no same-cycle accept.
    - If the holding register is empty: x_cur is retained and underrun <= 1.
  - The integrator update on the load tick still uses the old x_cur.
- underrun is cleared only by rst.
- Stable input range is |din| <= FS/2. Beyond that the modulator may limit-cycle, but the integrators saturate and never wrap.
- enable=0 in mid-stream: all state holds exactly. On enable=1 the interrupted div_cnt continues from where it stopped.
- rst mid-stream: all state is restored to reset values on that edge, overriding tick, load and accept.
- Latency: a PCM word accepted before load tick k first affects the bit emitted at load tick k+1.

Decomposition:
- Shared package sd_pkg holds:
  - SD_BIT_POS=2'sb01 and SD_BIT_NEG=2'sb11.
  - Default CLK_DIV/OSR/DIN_W/ACC_W constants, shared with the Mul_CIC bench.
  - A saturating-add function.
- One sub-module, sd_tick_gen, holds the CLK_DIV divider and the OSR counter. It outputs tick and load_tick.

Test Plan:
- Reset then enable=1 with no din: bit_valid pulses at edges 98, 196, 294, ... after reset release. bit_out sequence is +1,-1,-1,+1 repeating with period 4. underrun=1 after the 128th tick.
- Provide din=0 before the first load tick: x_cur loads 0 at tick 128. underrun stays 0 and the bitstream is unchanged. din_ready drops on accept and rises one cycle after tick 128.
- Constant din=+16384 (FS/2), refilled each OSR: over 2048 bits the count of +1 is 1536±16. i1/i2 never reach saturation.
- din=+32767 held for 20 OSR periods: the integrators clamp at 8388607/-8388608 with no sign flip from wrap. bit_out stays legal (only 01/11).
- Pulse enable=0 for 500 cycles mid-period: no bit_valid while disabled. Bit timing resumes with the preserved div_cnt phase. The sequence matches the reference model with the gap removed.
- Assert rst for 1 cycle in the middle of a load tick with din_valid=1: all outputs return to reset values, no transfer occurs, and the sequence restarts at +1.
- Loopback into Mul_CIC with din set to a 1 kHz sine at amplitude FS/4: after settling, the CIC output is a 1 kHz sine with SNR ≥ 60 dB against the MATLAB model.
